// File: rtl/boot_rom_pkg.sv
// ============================================================================
// boot_rom_pkg : shared types and helpers for the boot ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 12
`endif

package boot_rom_pkg;

   localparam int WAIT_CNT_W = 8;

   typedef enum logic [0:0] {
      INSTR_PRIO  = 1'b0,
      DATA_FORCED = 1'b1
   } arb_state_e;

   typedef enum logic [0:0] {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } resp_owner_e;

   // Comparing the full byte address against words*4 is the same as
   // (addr>>2) < words, and it keeps every address bit in use.
   function automatic logic addr_in_range(input logic [31:0] byte_addr,
                                          input int unsigned words);
      return byte_addr < (words * 4);
   endfunction

endpackage

`default_nettype wire

// File: rtl/boot_rom_starve_cnt.sv
// ============================================================================
// boot_rom_starve_cnt : data-port starvation counter and forced-priority FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module boot_rom_starve_cnt
   import boot_rom_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic data_req_i,
   input  logic data_gnt_i,
   output logic forced_o
);

   localparam logic [WAIT_CNT_W-1:0] C_LAST_WAIT = WAIT_CNT_W'(MAX_WAIT - 1);

   arb_state_e             state_q, state_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic                   denied;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= INSTR_PRIO;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      denied     = data_req_i & ~data_gnt_i;

      if (denied) begin
         wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
      end

      case (state_q)
         INSTR_PRIO: begin
            if (denied && (wait_cnt_q == C_LAST_WAIT)) begin
               state_d = DATA_FORCED;
            end
         end
         DATA_FORCED: begin
            if (data_gnt_i || !data_req_i) begin
               state_d = INSTR_PRIO;
            end
         end
         default: state_d = INSTR_PRIO;
      endcase
   end

   assign forced_o = (state_q == DATA_FORCED);

endmodule

`default_nettype wire

// File: rtl/boot_rom_arb.sv
// ============================================================================
// boot_rom_arb : two-port arbiter/sequencer sharing the single-port boot ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module boot_rom_arb
   import boot_rom_pkg::*;
#(
   parameter int          ADDR_WIDTH     = `ROM_ADDR_WIDTH,
   parameter int          DATA_WIDTH     = 32,
   parameter int unsigned BOOT_CODE_SIZE = 234,
   parameter int          MAX_WAIT       = 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [DATA_WIDTH-1:0] instr_rdata_o,

   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  data_err_o,

   output logic                  rom_en_o,
   output logic [ADDR_WIDTH-3:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

   logic                  forced;
   logic                  instr_win;
   logic                  data_win;
   logic [ADDR_WIDTH-1:0] winner_addr;
   logic                  in_range;

   logic                  resp_valid_q, resp_valid_d;
   resp_owner_e           resp_owner_q, resp_owner_d;
   logic                  resp_err_q,   resp_err_d;
   logic [DATA_WIDTH-1:0] resp_data;

   boot_rom_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_cnt (
      .clk        (clk),
      .rst        (rst),
      .data_req_i (data_req_i),
      .data_gnt_i (data_gnt_o),
      .forced_o   (forced)
   );

   always_comb begin
      instr_win = 1'b0;
      data_win  = 1'b0;
      if (forced) begin
         if (data_req_i) begin
            data_win = 1'b1;
         end else if (instr_req_i) begin
            instr_win = 1'b1;
         end
      end else begin
         if (instr_req_i) begin
            instr_win = 1'b1;
         end else if (data_req_i) begin
            data_win = 1'b1;
         end
      end
   end

   // Grants are combinational from req, so reset must mask them explicitly.
   assign instr_gnt_o = instr_win & ~rst;
   assign data_gnt_o  = data_win  & ~rst;

   assign winner_addr = data_win ? data_addr_i : instr_addr_i;
   assign in_range    = addr_in_range(32'(winner_addr), BOOT_CODE_SIZE);
   assign rom_en_o    = (instr_gnt_o | data_gnt_o) & in_range;
   assign rom_addr_o  = winner_addr[ADDR_WIDTH-1:2];

   assign resp_valid_d = instr_gnt_o | data_gnt_o;
   assign resp_owner_d = data_gnt_o ? OWNER_DATA : OWNER_INSTR;
   assign resp_err_d   = ~in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_owner_q <= OWNER_INSTR;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_owner_q <= resp_owner_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Out-of-range reads return zero to either port; only data sees the error.
   assign resp_data      = resp_err_q ? '0 : rom_rdata_i;

   assign instr_rvalid_o = resp_valid_q & (resp_owner_q == OWNER_INSTR);
   assign data_rvalid_o  = resp_valid_q & (resp_owner_q == OWNER_DATA);
   assign instr_rdata_o  = instr_rvalid_o ? resp_data : '0;
   assign data_rdata_o   = data_rvalid_o  ? resp_data : '0;
   assign data_err_o     = data_rvalid_o & resp_err_q;

endmodule

`default_nettype wire
